// File: rtl/syn_fifo_param.sv
// syn_fifo_param: parametrised synchronous FIFO with occupancy count, threshold flags and error pulses.
// Define SYN_FIFO_FWFT_EN for first-word-fall-through reads; default is a registered 1-cycle-latency read.
module syn_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 8,
    parameter int AF_THRESH  = 6,
    parameter int AE_THRESH  = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_ena,
    input  logic [DATA_WIDTH-1:0]      data_in,
    input  logic                       rd_ena,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] AF = (AW+1)'(AF_THRESH);
    localparam logic [AW:0] AE = (AW+1)'(AE_THRESH);
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic wr_acc, rd_acc;
    assign count        = wr_ptr - rd_ptr;
    assign empty        = wr_ptr == rd_ptr;
    assign full         = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
    assign almost_full  = count >= AF;
    assign almost_empty = count <= AE;
    assign wr_acc       = wr_ena && !full;
    assign rd_acc       = rd_ena && !empty;
    always_ff @(posedge clk) begin
        if (wr_acc && !rst) mem[wr_ptr[AW-1:0]] <= data_in;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            wr_ptr    <= wr_acc ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr    <= rd_acc ? rd_ptr + 1'b1 : rd_ptr;
            overflow  <= wr_ena && full;
            underflow <= rd_ena && empty;
        end
    end
`ifdef SYN_FIFO_FWFT_EN
    assign data_out = empty ? '0 : mem[rd_ptr[AW-1:0]];
`else
    always_ff @(posedge clk) begin
        if (rst) data_out <= '0;
        else if (rd_acc) data_out <= mem[rd_ptr[AW-1:0]];
    end
`endif
endmodule

// File: tb/tb_syn_fifo_param.sv
// tb_syn_fifo_param: directed self-checking bench for syn_fifo_param (8x8, AF=6, AE=2).
module tb_syn_fifo_param;
    logic clk = 0, rst = 0, wr_ena = 0, rd_ena = 0;
    logic [7:0] data_in = 0, data_out;
    logic full, empty, almost_full, almost_empty, overflow, underflow;
    logic [3:0] count;
    int tests = 0, fails = 0;

    syn_fifo_param #(.DATA_WIDTH(8), .DEPTH(8), .AF_THRESH(6), .AE_THRESH(2)) dut (
        .clk(clk), .rst(rst), .wr_ena(wr_ena), .data_in(data_in), .rd_ena(rd_ena),
        .data_out(data_out), .full(full), .empty(empty), .almost_full(almost_full),
        .almost_empty(almost_empty), .count(count), .overflow(overflow), .underflow(underflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        if (got != exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] d);
        wr_ena = 1; data_in = d;
        step();
        wr_ena = 0;
    endtask

    task automatic pop(input logic [7:0] exp);
`ifdef SYN_FIFO_FWFT_EN
        check("rd_data", int'(data_out), int'(exp));
        rd_ena = 1;
        step();
`else
        rd_ena = 1;
        step();
        check("rd_data", int'(data_out), int'(exp));
`endif
        rd_ena = 0;
    endtask

    initial begin
        rst = 1;
        step(); step();
        rst = 0;
        check("rst_count", int'(count), 0);
        check("rst_empty", int'(empty), 1);
        check("rst_ae", int'(almost_empty), 1);
        check("rst_full", int'(full), 0);
        check("rst_af", int'(almost_full), 0);
        check("rst_data", int'(data_out), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_unf", int'(underflow), 0);

        for (int i = 1; i <= 8; i++) begin
            push(8'(i * 'h11));
            check("fill_count", int'(count), i);
            check("fill_af", int'(almost_full), int'(i >= 6));
            check("fill_ae", int'(almost_empty), int'(i <= 2));
            check("fill_full", int'(full), int'(i == 8));
            check("fill_empty", int'(empty), 0);
        end
        push(8'h99);
        check("ovf_pulse", int'(overflow), 1);
        check("ovf_count", int'(count), 8);
        step();
        check("ovf_clear", int'(overflow), 0);

        for (int i = 1; i <= 8; i++) begin
            pop(8'(i * 'h11));
            check("drain_count", int'(count), 8 - i);
            check("drain_full", int'(full), 0);
            check("drain_empty", int'(empty), int'(i == 8));
        end
        rd_ena = 1;
        step();
        rd_ena = 0;
        check("unf_pulse", int'(underflow), 1);
        check("unf_count", int'(count), 0);
`ifdef SYN_FIFO_FWFT_EN
        check("unf_data", int'(data_out), 0);
`else
        check("unf_data", int'(data_out), 'h88);
`endif
        step();
        check("unf_clear", int'(underflow), 0);

        for (int r = 0; r < 3; r++) begin
            for (int k = 0; k < 5; k++) begin
                push(8'(r * 16 + k + 1));
                check("wrap_full", int'(full), 0);
            end
            check("wrap_count5", int'(count), 5);
            for (int k = 0; k < 5; k++) pop(8'(r * 16 + k + 1));
            check("wrap_count0", int'(count), 0);
            check("wrap_empty", int'(empty), 1);
        end

        for (int k = 0; k < 8; k++) push(8'('hC0 + k));
        check("sim_full", int'(full), 1);
        wr_ena = 1; data_in = 8'hAA;
        pop(8'hC0);
        wr_ena = 0;
        check("sim_ovf", int'(overflow), 1);
        check("sim_count7", int'(count), 7);
        for (int k = 1; k <= 4; k++) pop(8'('hC0 + k));
        check("sim_count3", int'(count), 3);
        wr_ena = 1; data_in = 8'hBB;
        pop(8'hC5);
        wr_ena = 0;
        check("sim_count_hold", int'(count), 3);
        check("sim_no_ovf", int'(overflow), 0);
        check("sim_no_unf", int'(underflow), 0);
        pop(8'hC6);
        pop(8'hC7);
        pop(8'hBB);
        check("sim_empty", int'(empty), 1);

        for (int k = 0; k < 5; k++) push(8'(k + 'h30));
        check("mid_count5", int'(count), 5);
        rst = 1; wr_ena = 1; data_in = 8'h77;
        step();
        rst = 0; wr_ena = 0;
        check("mid_rst_count", int'(count), 0);
        check("mid_rst_empty", int'(empty), 1);
        check("mid_rst_data", int'(data_out), 0);
        step();
        check("mid_rst_hold", int'(count), 0);
        push(8'h5A);
        check("post_rst_count", int'(count), 1);
`ifdef SYN_FIFO_FWFT_EN
        check("fwft_show", int'(data_out), 'h5A);
`endif
        pop(8'h5A);
        check("post_rst_empty", int'(empty), 1);

        wr_ena = 1; rd_ena = 1; data_in = 8'h3C;
        step();
        wr_ena = 0; rd_ena = 0;
        check("emp_both_unf", int'(underflow), 1);
        check("emp_both_count", int'(count), 1);
        pop(8'h3C);
        check("final_empty", int'(empty), 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
